key_event_decoder: RTL and testbench
====================================

KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 Parameter LONG_CYC, default 50_000_000: press-hold cycles to declare a long press (1 s at 50 MHz).
REQ-002 Parameter DBL_CYC, default 15_000_000: post-release window in cycles for a second press (300 ms).
REQ-003 Parameter RPT_CYC, default 10_000_000: auto-repeat period in cycles while long-held (200 ms).
REQ-004 Parameter CNT_W, default 32: internal counter width; all cycle parameters SHALL be >= 2 and < 2^CNT_W.
REQ-005 sys_clk  input  1  system clock, 50 MHz.
REQ-006 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 key_flag  input  1  one-cycle strobe from the debouncer; key_value is valid when high.
REQ-008 key_value  input  1  debounced key level; 0 = pressed, 1 = released.
REQ-009 short_pulse  output  1  one-cycle strobe: single short click.
REQ-010 double_pulse  output  1  one-cycle strobe: double click.
REQ-011 long_pulse  output  1  one-cycle strobe: hold reached LONG_CYC.
REQ-012 repeat_pulse  output  1  one-cycle strobe: each auto-repeat period during a long hold.
REQ-013 key_held  output  1  level: high while the FSM considers the key pressed.

Function
REQ-014 Press event = key_flag & ~key_value; release event = key_flag & key_value; key_value without key_flag SHALL be ignored.
REQ-015 FSM states: IDLE, PRESS1, WAIT2, PRESS2, LONG; one shared counter cnt, cleared to 0 on every state entry, incremented by 1 each cycle spent in a non-IDLE state, held at 0 in IDLE.
REQ-016 IDLE: press -> PRESS1; release ignored.
REQ-017 PRESS1: release -> WAIT2; else cnt == LONG_CYC-1 -> LONG and assert long_pulse.
REQ-018 WAIT2: press -> PRESS2; else cnt == DBL_CYC-1 -> IDLE and assert short_pulse.
REQ-019 PRESS2: release -> IDLE and assert double_pulse; else cnt == LONG_CYC-1 -> LONG and assert long_pulse (no double_pulse, no short_pulse).
REQ-020 LONG: release -> IDLE, no other pulse; else cnt == RPT_CYC-1 -> assert repeat_pulse, clear cnt, stay in LONG.
REQ-021 Redundant events (press in PRESS1/PRESS2/LONG, release in IDLE/WAIT2) SHALL be ignored without state or counter change.
REQ-022 When an event and a timeout fall in the same cycle, the event SHALL win and the timeout pulse SHALL NOT be asserted.
REQ-023 All outputs registered; each pulse is high for exactly the one cycle following the clock edge at which its transition is taken; pulses are mutually exclusive.
REQ-024 Latency: short_pulse follows DBL_CYC edges after the edge sampling the release; long_pulse follows LONG_CYC edges after the edge sampling the press; first repeat_pulse RPT_CYC edges after long_pulse's edge, then every RPT_CYC edges.
REQ-025 key_held SHALL be high in the cycle after entry to PRESS1, PRESS2, or LONG and low in the cycle after entry to IDLE or WAIT2.

Reset
REQ-026 sys_rst_n low SHALL asynchronously force state IDLE, cnt 0, and all five outputs 0.
REQ-027 Reset asserted mid-operation (any state) SHALL abort that gesture with no pulse emitted on or after release of reset until a new press event.
REQ-028 After reset release, the first valid action SHALL be a press event in IDLE.

Verification (LONG_CYC=20, DBL_CYC=8, RPT_CYC=5)
REQ-029 Reset: hold sys_rst_n low with key_flag toggling -> all outputs 0; release reset, no events -> outputs stay 0.
REQ-030 Press, release 5 cycles later, idle -> short_pulse high for 1 cycle 8 edges after the release edge; key_held high 5 cycles; no other pulse.
REQ-031 Press, release, press 3 cycles after release, release 4 cycles later -> double_pulse 1 cycle after the second release edge; no short_pulse.
REQ-032 Press held 37 cycles then release -> long_pulse at edge 20, repeat_pulse at edges 25, 30, 35; key_held falls after release; no short_pulse.
REQ-033 In WAIT2, press flag on the cycle where cnt == 7 -> PRESS2 entered, no short_pulse; subsequent release -> double_pulse.
REQ-034 Assert reset during LONG between repeat pulses -> outputs 0 immediately; post-reset release flag -> no pulse.

Source files
------------

// File: rtl/key_event_if.sv
// Key event bundle between a debouncer-side producer and the key event decoder.
// key_flag is a one-cycle valid strobe with no ready: key_value is only meaningful while key_flag is high, and the decoder always accepts it; every output is a registered strobe or level.
interface key_event_if;
  logic key_flag;
  logic key_value;
  logic short_pulse;
  logic double_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic key_held;

  modport master (
    output key_flag,
    output key_value,
    input  short_pulse,
    input  double_pulse,
    input  long_pulse,
    input  repeat_pulse,
    input  key_held
  );

  modport slave (
    input  key_flag,
    input  key_value,
    output short_pulse,
    output double_pulse,
    output long_pulse,
    output repeat_pulse,
    output key_held
  );
endinterface

// File: rtl/key_event_decoder.sv
// Turns debounced key press/release strobes into short, double, long and auto-repeat gesture pulses.
// A single shared counter times the long-hold, double-click window and repeat period.
module key_event_decoder #(
  parameter int LONG_CYC = 50_000_000,
  parameter int DBL_CYC  = 15_000_000,
  parameter int RPT_CYC  = 10_000_000,
  parameter int CNT_W    = 32
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  key_event_if.slave    key_if,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  // Terminal counts: a transition fires on the edge where cnt already holds N-1.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(RPT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             short_q;
  logic             double_q;
  logic             long_q;
  logic             repeat_q;
  logic             held_q;
  logic             press_ev;
  logic             release_ev;

  assign press_ev   = key_if.key_flag & ~key_if.key_value;
  assign release_ev = key_if.key_flag &  key_if.key_value;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (press_ev) begin
            state  <= PRESS1;
            held_q <= 1'b1;
          end
        end

        PRESS1: begin
          // Events are checked before timeouts so a same-cycle event suppresses the pulse.
          if (release_ev) begin
            state  <= WAIT2;
            cnt    <= '0;
            held_q <= 1'b0;
          end else if (cnt == LONG_LAST) begin
            state  <= LONG;
            cnt    <= '0;
            long_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        WAIT2: begin
          if (press_ev) begin
            state  <= PRESS2;
            cnt    <= '0;
            held_q <= 1'b1;
          end else if (cnt == DBL_LAST) begin
            state   <= IDLE;
            cnt     <= '0;
            short_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        PRESS2: begin
          if (release_ev) begin
            state    <= IDLE;
            cnt      <= '0;
            held_q   <= 1'b0;
            double_q <= 1'b1;
          end else if (cnt == LONG_LAST) begin
            state  <= LONG;
            cnt    <= '0;
            long_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        LONG: begin
          // Ending a long hold is silent; only the periodic repeat produces pulses.
          if (release_ev) begin
            state  <= IDLE;
            cnt    <= '0;
            held_q <= 1'b0;
          end else if (cnt == RPT_LAST) begin
            cnt      <= '0;
            repeat_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state  <= IDLE;
          cnt    <= '0;
          held_q <= 1'b0;
        end
      endcase
    end
  end

  assign key_if.short_pulse  = short_q;
  assign key_if.double_pulse = double_q;
  assign key_if.long_pulse   = long_q;
  assign key_if.repeat_pulse = repeat_q;
  assign key_if.key_held     = held_q;
  assign state_dbg           = state;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with short timing parameters.
// Observed word per cycle is {key_held, short, double, long, repeat}.
module tb_key_event_decoder;

  localparam int LONG_CYC = 20;
  localparam int DBL_CYC  = 8;
  localparam int RPT_CYC  = 5;

  localparam logic [4:0] Z  = 5'b00000;
  localparam logic [4:0] H  = 5'b10000;
  localparam logic [4:0] S  = 5'b01000;
  localparam logic [4:0] D  = 5'b00100;
  localparam logic [4:0] HL = 5'b10010;
  localparam logic [4:0] HR = 5'b10001;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [2:0] state_dbg;
  int         n_tests;
  int         n_fail;

  logic [1:0] stim_q[$];
  logic [4:0] exp_q[$];

  key_event_if kif ();

  key_event_decoder #(
    .LONG_CYC (LONG_CYC),
    .DBL_CYC  (DBL_CYC),
    .RPT_CYC  (RPT_CYC),
    .CNT_W    (32)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_if    (kif),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  function automatic logic [4:0] obs_word();
    return {kif.key_held, kif.short_pulse, kif.double_pulse, kif.long_pulse, kif.repeat_pulse};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: queue n cycles of {flag,value} with the word expected after that edge
  task automatic push(input int n, input logic f, input logic v, input logic [4:0] e);
    for (int i = 0; i < n; i++) begin
      stim_q.push_back({f, v});
      exp_q.push_back(e);
    end
  endtask

  // Scoreboard: apply one stimulus per cycle and compare against the expected queue
  task automatic run_q(input string name);
    logic [1:0] s;
    int         c;
    c = 0;
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      kif.key_flag  = s[1];
      kif.key_value = s[0];
      @(posedge sys_clk);
      #1;
      check($sformatf("%s_c%0d", name, c), 32'(obs_word()), 32'(exp_q.pop_front()));
      c++;
    end
    kif.key_flag = 1'b0;
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    sys_rst_n     = 1'b0;
    kif.key_flag  = 1'b0;
    kif.key_value = 1'b1;

    // Reset held with key_flag toggling
    for (int i = 0; i < 4; i++) begin
      kif.key_flag  = ~kif.key_flag;
      kif.key_value = i[0];
      @(posedge sys_clk);
      #1;
      check($sformatf("rst_hold_c%0d", i), 32'(obs_word()), 32'(Z));
    end
    check("rst_state", 32'(state_dbg), 32'd0);
    kif.key_flag  = 1'b0;
    kif.key_value = 1'b1;
    sys_rst_n     = 1'b1;
    push(4, 1'b0, 1'b1, Z);
    run_q("rst_idle");

    // Short click, preceded by an IDLE release and an unflagged level change
    push(1, 1'b1, 1'b1, Z);
    push(2, 1'b0, 1'b0, Z);
    push(1, 1'b1, 1'b0, H);
    push(4, 1'b0, 1'b0, H);
    push(1, 1'b1, 1'b1, Z);
    push(7, 1'b0, 1'b1, Z);
    push(1, 1'b0, 1'b1, S);
    push(3, 1'b0, 1'b1, Z);
    run_q("short");

    // Double click
    push(1, 1'b1, 1'b0, H);
    push(4, 1'b0, 1'b0, H);
    push(1, 1'b1, 1'b1, Z);
    push(2, 1'b0, 1'b1, Z);
    push(1, 1'b1, 1'b0, H);
    push(3, 1'b0, 1'b0, H);
    push(1, 1'b1, 1'b1, D);
    push(10, 1'b0, 1'b1, Z);
    run_q("double");

    // Long hold for 37 cycles with a redundant press at cycle 10
    push(1, 1'b1, 1'b0, H);
    push(9, 1'b0, 1'b0, H);
    push(1, 1'b1, 1'b0, H);
    push(9, 1'b0, 1'b0, H);
    push(1, 1'b0, 1'b0, HL);
    for (int r = 0; r < 3; r++) begin
      push(4, 1'b0, 1'b0, H);
      push(1, 1'b0, 1'b0, HR);
    end
    push(1, 1'b0, 1'b0, H);
    push(1, 1'b1, 1'b1, Z);
    push(8, 1'b0, 1'b1, Z);
    run_q("long");

    // Second press lands on the WAIT2 timeout cycle; redundant release inside WAIT2
    push(1, 1'b1, 1'b0, H);
    push(1, 1'b0, 1'b0, H);
    push(1, 1'b1, 1'b1, Z);
    push(2, 1'b0, 1'b1, Z);
    push(1, 1'b1, 1'b1, Z);
    push(4, 1'b0, 1'b1, Z);
    push(1, 1'b1, 1'b0, H);
    push(3, 1'b0, 1'b0, H);
    push(1, 1'b1, 1'b1, D);
    push(10, 1'b0, 1'b1, Z);
    run_q("wait2_edge");

    // Release lands on the PRESS1 long timeout cycle: no long pulse, later short
    push(1, 1'b1, 1'b0, H);
    push(19, 1'b0, 1'b0, H);
    push(1, 1'b1, 1'b1, Z);
    push(7, 1'b0, 1'b1, Z);
    push(1, 1'b0, 1'b1, S);
    push(2, 1'b0, 1'b1, Z);
    run_q("press1_race");

    // Second press held to a long press, then a silent release
    push(1, 1'b1, 1'b0, H);
    push(1, 1'b1, 1'b1, Z);
    push(1, 1'b0, 1'b1, Z);
    push(1, 1'b1, 1'b0, H);
    push(19, 1'b0, 1'b0, H);
    push(1, 1'b0, 1'b0, HL);
    push(1, 1'b1, 1'b1, Z);
    push(10, 1'b0, 1'b1, Z);
    run_q("press2_long");

    // Reset asserted inside LONG between repeat pulses
    push(1, 1'b1, 1'b0, H);
    push(19, 1'b0, 1'b0, H);
    push(1, 1'b0, 1'b0, HL);
    push(2, 1'b0, 1'b0, H);
    run_q("pre_reset");
    #3;
    sys_rst_n = 1'b0;
    #1;
    check("async_rst_out", 32'(obs_word()), 32'(Z));
    check("async_rst_state", 32'(state_dbg), 32'd0);
    @(posedge sys_clk);
    #1;
    check("rst_in_long_out", 32'(obs_word()), 32'(Z));
    sys_rst_n = 1'b1;
    push(1, 1'b1, 1'b1, Z);
    push(12, 1'b0, 1'b1, Z);
    run_q("post_reset");

    // Normal operation resumes after the aborted gesture
    push(1, 1'b1, 1'b0, H);
    push(1, 1'b0, 1'b0, H);
    push(1, 1'b1, 1'b1, Z);
    push(7, 1'b0, 1'b1, Z);
    push(1, 1'b0, 1'b1, S);
    push(2, 1'b0, 1'b1, Z);
    run_q("recover");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
